// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared FSM encoding and reset constants for the fetch stage
package fetch_unit_pkg;
    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_WAIT   = 2'b01,
        ST_HALTED = 2'b10
    } state_e;
    localparam logic [15:0] NOP_OPCODE   = 16'h0800;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: output register holding the fetched instruction for decode
//   load/load_instr/load_pc : capture a returned instruction and its PC
//   consume                 : decode took the instruction (valid & ~stall)
//   flush                   : drop any held instruction (redirect/halt)
//   instruction/pc_out/pc_plus2/inst_valid : registered outputs to decode
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] NOP_INSTR = NOP_OPCODE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             consume,
    input  logic             flush,
    input  logic [WIDTH-1:0] load_instr,
    input  logic [WIDTH-1:0] load_pc,
    output logic [WIDTH-1:0] instruction,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus2,
    output logic             inst_valid
);
    logic [WIDTH-1:0] instr_q, instr_d, pc_q, pc_d, pc2_q, pc2_d;
    logic             valid_q, valid_d;

    // flush beats load beats consume; a load on the consume edge refills
    always_comb begin
        valid_d = flush ? 1'b0 : load ? 1'b1 : consume ? 1'b0 : valid_q;
        instr_d = load ? load_instr : instr_q;
        pc_d    = load ? load_pc : pc_q;
        pc2_d   = load ? load_pc + WIDTH'(2) : pc2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            pc2_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc2_q   <= pc2_d;
            valid_q <= valid_d;
        end
    end

    assign instruction = instr_q;
    assign pc_out      = pc_q;
    assign pc_plus2    = pc2_q;
    assign inst_valid  = valid_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC + single-outstanding-request fetch FSM feeding decode
//   stall/halt/redirect/redirect_pc : control from decode
//   imem_req/imem_addr              : request to instruction memory
//   imem_rdata/imem_valid/imem_err  : memory response
//   instruction/pc_out/pc_plus2/inst_valid : buffered instruction to decode
//   halted/err                      : stage stopped / sticky memory error
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [WIDTH-1:0] NOP_INSTR = NOP_OPCODE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             halt,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             imem_valid,
    input  logic             imem_err,
    output logic [WIDTH-1:0] instruction,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus2,
    output logic             inst_valid,
    output logic             halted,
    output logic             err
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             squash_q, squash_d, halted_q, halted_d, err_q, err_d;
    logic             consume, halt_go, load, flush, req;

    assign consume = inst_valid & ~stall;
    assign halt_go = halt & consume;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        squash_d = squash_q;
        halted_d = halted_q;
        err_d    = err_q;
        load     = 1'b0;
        flush    = 1'b0;
        req      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (halt_go) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                    flush    = 1'b1;
                end else if (redirect) begin
                    pc_d  = redirect_pc;
                    flush = 1'b1;
                end else if (~inst_valid | ~stall) begin
                    // buffer is empty or drains this edge, so the reply cannot clobber it
                    req     = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (halt_go) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                    flush    = 1'b1;
                end else if (imem_valid & (squash_q | redirect)) begin
                    // reply belongs to a stale path; drop it, error included
                    squash_d = 1'b0;
                    flush    = 1'b1;
                    state_d  = ST_FETCH;
                    if (redirect) pc_d = redirect_pc;
                end else if (redirect) begin
                    pc_d     = redirect_pc;
                    flush    = 1'b1;
                    squash_d = 1'b1;
                end else if (imem_valid & imem_err) begin
                    err_d    = 1'b1;
                    halted_d = 1'b1;
                    flush    = 1'b1;
                    state_d  = ST_HALTED;
                end else if (imem_valid) begin
                    load    = 1'b1;
                    pc_d    = pc_q + WIDTH'(2);
                    state_d = ST_FETCH;
                end
            end
            ST_HALTED: flush = 1'b1;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            squash_q <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            squash_q <= squash_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    fetch_buffer #(.WIDTH(WIDTH), .NOP_INSTR(NOP_INSTR)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .consume    (consume),
        .flush      (flush),
        .load_instr (imem_rdata),
        .load_pc    (pc_q),
        .instruction(instruction),
        .pc_out     (pc_out),
        .pc_plus2   (pc_plus2),
        .inst_valid (inst_valid)
    );

    // reset gating keeps the request low while rst is held
    assign imem_req  = rst & req;
    assign imem_addr = pc_q;
    assign halted    = halted_q;
    assign err       = err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for the fetch stage
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall, redirect, halt, imem_valid, imem_err;
    logic [15:0] redirect_pc, imem_rdata;
    logic        imem_req, inst_valid, halted, err;
    logic [15:0] imem_addr, instruction, pc_out, pc_plus2;

    typedef struct {
        logic [15:0] data;
        logic [15:0] pc;
    } exp_t;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .imem_err   (imem_err),
        .instruction(instruction),
        .pc_out     (pc_out),
        .pc_plus2   (pc_plus2),
        .inst_valid (inst_valid),
        .halted     (halted),
        .err        (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        stall = 0; redirect = 0; redirect_pc = 0; halt = 0;
        imem_valid = 0; imem_err = 0; imem_rdata = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        drive_idle();
        exp_q.delete();
        tick();
        tick();
        rst = 1;
    endtask

    // waits (bounded) for a request and checks its address
    task automatic wait_req(input logic [15:0] want);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (imem_req === 1'b1) seen = 1;
            else tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL req_timeout: no imem_req, expected addr %h", want);
        end else if (imem_addr !== want) begin
            errors++;
            $display("FAIL req_addr: got %h want %h", imem_addr, want);
        end
    endtask

    // respond k=lat cycles after the request cycle the caller is in
    task automatic respond(input logic [15:0] data, input bit e, input int lat);
        tick();
        repeat (lat - 1) tick();
        imem_valid = 1; imem_rdata = data; imem_err = e;
        tick();
        imem_valid = 0; imem_err = 0;
    endtask

    task automatic fetch(input logic [15:0] addr, input logic [15:0] data);
        exp_t e;
        wait_req(addr);
        e.data = data;
        e.pc   = addr;
        exp_q.push_back(e);
        respond(data, 0, 1);
    endtask

    task automatic check_out(input string name);
        exp_t        e;
        logic [15:0] p2;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, inst_valid=%b", name, inst_valid);
        end else begin
            e  = exp_q.pop_front();
            p2 = e.pc + 16'd2;
            if (inst_valid !== 1'b1 || instruction !== e.data || pc_out !== e.pc || pc_plus2 !== p2) begin
                errors++;
                $display("FAIL %s: got v=%b i=%h pc=%h pc2=%h want v=1 i=%h pc=%h pc2=%h",
                         name, inst_valid, instruction, pc_out, pc_plus2, e.data, e.pc, p2);
            end
        end
    endtask

    task automatic test_reset();
        drive_idle();
        #2 rst = 0;
        #2;
        checks++;
        if (instruction !== 16'h0800 || pc_out !== 16'h0 || pc_plus2 !== 16'h0 ||
            inst_valid !== 1'b0 || halted !== 1'b0 || err !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got i=%h pc=%h pc2=%h v=%b h=%b e=%b req=%b want i=0800 pc=0 pc2=0 v=0 h=0 e=0 req=0",
                     instruction, pc_out, pc_plus2, inst_valid, halted, err, imem_req);
        end
        tick();
        rst = 1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        fetch(16'h0000, 16'hC123);
        check_out("b2b_first");
        fetch(16'h0002, 16'hC456);
        check_out("b2b_second");
    endtask

    task automatic test_stall();
        do_reset();
        fetch(16'h0000, 16'hC123);
        stall = 1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_req0: got %b want 0", imem_req);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b1 || instruction !== 16'hC123 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: got v=%b i=%h req=%b want v=1 i=c123 req=0",
                         inst_valid, instruction, imem_req);
            end
        end
        stall = 0;
        check_out("stall_release");
        wait_req(16'h0002);
    endtask

    task automatic test_redirect();
        do_reset();
        fetch(16'h0000, 16'h1111);
        check_out("redir_pre0");
        fetch(16'h0002, 16'h2222);
        check_out("redir_pre1");
        wait_req(16'h0004);
        tick();
        redirect = 1; redirect_pc = 16'h0100;
        tick();
        redirect = 0;
        imem_valid = 1; imem_rdata = 16'hDEAD;
        tick();
        imem_valid = 0;
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_squash: got inst_valid=%b want 0", inst_valid);
        end
        fetch(16'h0100, 16'hC789);
        check_out("redir_target");
    endtask

    task automatic test_halt();
        do_reset();
        fetch(16'h0000, 16'hF000);
        halt = 1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_noreq: got %b want 0", imem_req);
        end
        check_out("halt_instr");
        tick();
        halt = 0;
        checks++;
        if (halted !== 1'b1 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_enter: got h=%b v=%b want h=1 v=0", halted, inst_valid);
        end
        redirect = 1; redirect_pc = 16'h0200;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (imem_req !== 1'b0 || halted !== 1'b1) begin
                errors++;
                $display("FAIL halt_stuck: got req=%b h=%b want req=0 h=1", imem_req, halted);
            end
            tick();
        end
        redirect = 0;
    endtask

    task automatic test_err();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            fetch(16'(2 * i), 16'hA000 + 16'(i));
            check_out("err_pre");
        end
        wait_req(16'h0006);
        respond(16'hBAD0, 1, 1);
        checks++;
        if (err !== 1'b1 || halted !== 1'b1 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_enter: got e=%b h=%b v=%b want e=1 h=1 v=0", err, halted, inst_valid);
        end
        redirect = 1; redirect_pc = 16'h0040; imem_valid = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (err !== 1'b1 || halted !== 1'b1 || inst_valid !== 1'b0 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL err_sticky: got e=%b h=%b v=%b req=%b want e=1 h=1 v=0 req=0",
                         err, halted, inst_valid, imem_req);
            end
        end
        do_reset();
        checks++;
        if (err !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got e=%b h=%b want e=0 h=0", err, halted);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect = 1; redirect_pc = 16'hFFFE;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL wrap_redir_noreq: got %b want 0", imem_req);
        end
        tick();
        redirect = 0;
        fetch(16'hFFFE, 16'hC0DE);
        check_out("wrap_buf");
        wait_req(16'h0000);
    endtask

    task automatic test_async_reset();
        do_reset();
        fetch(16'h0000, 16'h3333);
        check_out("ar_pre0");
        fetch(16'h0002, 16'h4444);
        check_out("ar_pre1");
        wait_req(16'h0004);
        tick();
        #2 rst = 0;
        #1;
        checks++;
        if (instruction !== 16'h0800 || pc_out !== 16'h0 || pc_plus2 !== 16'h0 ||
            inst_valid !== 1'b0 || halted !== 1'b0 || err !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got i=%h pc=%h pc2=%h v=%b h=%b e=%b req=%b want i=0800 pc=0 pc2=0 v=0 h=0 e=0 req=0",
                     instruction, pc_out, pc_plus2, inst_valid, halted, err, imem_req);
        end
        tick();
        rst = 1;
        wait_req(16'h0000);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_redirect();
        test_halt();
        test_err();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
